// File: rtl/counter_updown_mod_if.sv
// Control and status bundle for one up/down count channel.
// The master drives requests and configuration; the slave is the counter itself.
interface counter_updown_mod_if #(
  parameter int WIDTH      = 8,
  parameter int STEP_WIDTH = 4
);
  logic                  enable;
  logic                  count;
  logic                  direction;
  logic [STEP_WIDTH-1:0] step;
  logic                  load;
  logic [WIDTH-1:0]      load_value;
  logic [WIDTH-1:0]      limit;
  logic                  saturate;
  logic                  clear_flags;
  logic [WIDTH-1:0]      counter_value;
  logic                  terminal;
  logic                  overflow;
  logic                  underflow;
  logic                  at_limit;
  logic                  at_zero;

  modport master (
    output enable, count, direction, step, load, load_value, limit, saturate, clear_flags,
    input  counter_value, terminal, overflow, underflow, at_limit, at_zero
  );

  modport slave (
    input  enable, count, direction, step, load, load_value, limit, saturate, clear_flags,
    output counter_value, terminal, overflow, underflow, at_limit, at_zero
  );
endinterface

// File: rtl/counter_updown_mod.sv
// Up/down counter with programmable step and modulus, wrap or saturate at the
// range bounds, a one-cycle terminal pulse and sticky overflow/underflow flags.
module counter_updown_mod #(
  parameter int WIDTH      = 8,
  parameter int STEP_WIDTH = 4
) (
  input logic                  clock,
  input logic                  reset,
  counter_updown_mod_if.slave  bus
);

  logic [WIDTH-1:0] valueReg;
  logic             terminalReg;
  logic             overflowReg;
  logic             underflowReg;

  logic             countEvent;
  logic [WIDTH:0]   valueExt;
  logic [WIDTH:0]   limitExt;
  logic [WIDTH:0]   stepExt;
  logic [WIDTH:0]   modulus;
  logic [WIDTH:0]   upSum;
  logic [WIDTH:0]   upWrap;
  logic [WIDTH:0]   downDiff;
  logic [WIDTH:0]   downWrap;
  logic [WIDTH-1:0] nextValue;
  logic             boundary;
  logic             setOverflow;
  logic             setUnderflow;

  // All arithmetic is one bit wider than the counter so limit = all-ones gives a
  // full 2^WIDTH modulus without losing the carry.
  always_comb begin
    countEvent   = bus.enable & bus.count & ~bus.load & (bus.step != '0);
    valueExt     = {1'b0, valueReg};
    limitExt     = {1'b0, bus.limit};
    stepExt      = {{(WIDTH + 1 - STEP_WIDTH){1'b0}}, bus.step};
    modulus      = limitExt + 1'b1;
    upSum        = valueExt + stepExt;
    upWrap       = upSum - modulus;
    downDiff     = valueExt - stepExt;
    downWrap     = valueExt + modulus - stepExt;
    nextValue    = valueReg;
    boundary     = 1'b0;
    setOverflow  = 1'b0;
    setUnderflow = 1'b0;

    if (valueExt > limitExt) begin
      nextValue    = bus.limit;
      boundary     = 1'b1;
      setOverflow  = ~bus.direction;
      setUnderflow = bus.direction;
    end else if (!bus.direction) begin
      if (upSum > limitExt) begin
        nextValue   = bus.saturate ? bus.limit : upWrap[WIDTH-1:0];
        boundary    = 1'b1;
        setOverflow = 1'b1;
      end else begin
        nextValue = upSum[WIDTH-1:0];
      end
    end else begin
      if (stepExt > valueExt) begin
        nextValue    = bus.saturate ? '0 : downWrap[WIDTH-1:0];
        boundary     = 1'b1;
        setUnderflow = 1'b1;
      end else begin
        nextValue = downDiff[WIDTH-1:0];
      end
    end
  end

  // Load beats count; a flag set in the same cycle as clear_flags survives the clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      valueReg     <= '0;
      terminalReg  <= 1'b0;
      overflowReg  <= 1'b0;
      underflowReg <= 1'b0;
    end else begin
      terminalReg <= 1'b0;
      if (bus.enable && bus.load) begin
        valueReg <= bus.load_value;
      end else if (countEvent) begin
        valueReg    <= nextValue;
        terminalReg <= boundary;
      end
      overflowReg  <= (countEvent & setOverflow)  | (overflowReg  & ~bus.clear_flags);
      underflowReg <= (countEvent & setUnderflow) | (underflowReg & ~bus.clear_flags);
    end
  end

  assign bus.counter_value = valueReg;
  assign bus.terminal      = terminalReg;
  assign bus.overflow      = overflowReg;
  assign bus.underflow     = underflowReg;
  assign bus.at_limit      = (valueReg == bus.limit);
  assign bus.at_zero       = (valueReg == '0);

endmodule

// File: tb/tb_counter_updown_mod.sv
// Directed-vector bench for counter_updown_mod with hand-computed expectations.
module tb_counter_updown_mod;

  logic clock;
  logic reset;
  int   vectorCount;
  int   missCount;

  counter_updown_mod_if #(.WIDTH(8), .STEP_WIDTH(4)) bus ();

  counter_updown_mod #(.WIDTH(8), .STEP_WIDTH(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic checkState(input string tag, input int value, input bit term, input bit ovf, input bit und);
    checkOutput({tag, ".value"},     32'(bus.counter_value), 32'(value));
    checkOutput({tag, ".terminal"},  32'(bus.terminal),      32'(term));
    checkOutput({tag, ".overflow"},  32'(bus.overflow),      32'(ovf));
    checkOutput({tag, ".underflow"}, 32'(bus.underflow),     32'(und));
  endtask

  // Drives one cycle of inputs, clocks it and settles just past the edge.
  task automatic applyStimulus(input bit en, input bit cnt, input bit dir, input logic [3:0] st,
                               input bit ld, input logic [7:0] ldv, input logic [7:0] lim,
                               input bit sat, input bit clr);
    bus.enable      = en;
    bus.count       = cnt;
    bus.direction   = dir;
    bus.step        = st;
    bus.load        = ld;
    bus.load_value  = ldv;
    bus.limit       = lim;
    bus.saturate    = sat;
    bus.clear_flags = clr;
    @(posedge clock);
    #1;
  endtask

  initial begin
    vectorCount = 0;
    missCount   = 0;
    reset       = 1'b1;
    bus.enable = 0; bus.count = 0; bus.direction = 0; bus.step = 0; bus.load = 0;
    bus.load_value = 0; bus.limit = 8'd9; bus.saturate = 0; bus.clear_flags = 0;
    repeat (2) @(posedge clock);
    #1;
    checkState("reset", 0, 0, 0, 0);
    checkOutput("reset.at_zero", 32'(bus.at_zero), 32'd1);
    reset = 1'b0;

    // up count step 1, limit 9
    applyStimulus(1, 1, 0, 4'd1, 0, 8'd0, 8'd9, 0, 0);
    checkState("up1", 1, 0, 0, 0);
    checkOutput("up1.at_zero", 32'(bus.at_zero), 32'd0);
    applyStimulus(1, 1, 0, 4'd1, 0, 8'd0, 8'd9, 0, 0);
    checkState("up2", 2, 0, 0, 0);
    applyStimulus(1, 1, 0, 4'd1, 0, 8'd0, 8'd9, 0, 0);
    checkState("up3", 3, 0, 0, 0);

    // wrap up: 8 + 3 - 10 = 1
    applyStimulus(1, 0, 0, 4'd3, 1, 8'd8, 8'd9, 0, 0);
    checkState("load8", 8, 0, 0, 0);
    applyStimulus(1, 1, 0, 4'd3, 0, 8'd0, 8'd9, 0, 0);
    checkState("wrapUp", 1, 1, 1, 0);
    applyStimulus(1, 0, 0, 4'd3, 0, 8'd0, 8'd9, 0, 0);
    checkState("wrapUpIdle", 1, 0, 1, 0);

    // landing exactly on limit is not a boundary event; step 0 is a no-op
    applyStimulus(1, 0, 0, 4'd4, 1, 8'd5, 8'd9, 0, 0);
    applyStimulus(1, 1, 0, 4'd4, 0, 8'd0, 8'd9, 0, 0);
    checkState("landLimit", 9, 0, 1, 0);
    checkOutput("landLimit.at_limit", 32'(bus.at_limit), 32'd1);
    applyStimulus(1, 1, 0, 4'd0, 0, 8'd0, 8'd9, 0, 0);
    checkState("stepZero", 9, 0, 1, 0);

    // saturate down from 2 with step 5, then again at the bound
    applyStimulus(1, 0, 0, 4'd0, 0, 8'd0, 8'd9, 0, 1);
    checkState("clear1", 9, 0, 0, 0);
    applyStimulus(1, 0, 1, 4'd5, 1, 8'd2, 8'd9, 1, 0);
    applyStimulus(1, 1, 1, 4'd5, 0, 8'd0, 8'd9, 1, 0);
    checkState("satDown", 0, 1, 0, 1);
    applyStimulus(1, 1, 1, 4'd5, 0, 8'd0, 8'd9, 1, 0);
    checkState("satDownAgain", 0, 1, 0, 1);
    applyStimulus(1, 0, 1, 4'd5, 0, 8'd0, 8'd9, 1, 0);
    checkState("satDownIdle", 0, 0, 0, 1);

    // full 8-bit modulus: 250 + 10 -> 4, 3 - 5 -> 254
    applyStimulus(1, 0, 0, 4'd0, 0, 8'd0, 8'd255, 0, 1);
    applyStimulus(1, 0, 0, 4'd10, 1, 8'd250, 8'd255, 0, 0);
    applyStimulus(1, 1, 0, 4'd10, 0, 8'd0, 8'd255, 0, 0);
    checkState("fullUp", 4, 1, 1, 0);
    applyStimulus(1, 0, 1, 4'd5, 1, 8'd3, 8'd255, 0, 0);
    checkState("load3", 3, 0, 1, 0);
    applyStimulus(1, 1, 1, 4'd5, 0, 8'd0, 8'd255, 0, 0);
    checkState("fullDown", 254, 1, 1, 1);

    // priority: load beats count; enable low holds and kills terminal
    applyStimulus(1, 1, 0, 4'd5, 1, 8'd77, 8'd255, 0, 0);
    checkState("loadBeatsCount", 77, 0, 1, 1);
    applyStimulus(1, 1, 0, 4'd5, 0, 8'd0, 8'd80, 1, 0);
    checkState("satUp", 80, 1, 1, 1);
    checkOutput("satUp.at_limit", 32'(bus.at_limit), 32'd1);
    applyStimulus(0, 1, 0, 4'd5, 1, 8'd5, 8'd80, 1, 0);
    checkState("disabledHold", 80, 0, 1, 1);
    applyStimulus(1, 1, 0, 4'd1, 0, 8'd0, 8'd80, 1, 1);
    checkState("setBeatsClear", 80, 1, 1, 0);

    // out-of-range value snaps to limit
    applyStimulus(1, 0, 0, 4'd1, 0, 8'd0, 8'd5, 0, 1);
    applyStimulus(1, 0, 0, 4'd1, 1, 8'd12, 8'd5, 0, 0);
    checkState("loadOutOfRange", 12, 0, 0, 0);
    checkOutput("loadOutOfRange.at_limit", 32'(bus.at_limit), 32'd0);
    applyStimulus(1, 1, 0, 4'd1, 0, 8'd0, 8'd5, 0, 0);
    checkState("outOfRange", 5, 1, 1, 0);

    // reset mid-count wins, first count afterwards starts from 0
    reset = 1'b1;
    applyStimulus(1, 1, 0, 4'd1, 0, 8'd0, 8'd9, 0, 0);
    checkState("midReset", 0, 0, 0, 0);
    reset = 1'b0;
    applyStimulus(1, 1, 0, 4'd1, 0, 8'd0, 8'd9, 0, 0);
    checkState("afterReset", 1, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
